// File: rtl/arbiter_rr_weighted.sv
// arbiter_rr_weighted
//
// Weighted round-robin arbiter with packet locking and a registered output
// stage. Several valid/ready input streams are merged into one output
// stream. A multi-beat packet (ended by in_last) is never interleaved with
// another port's beats. Port i may send up to max(weight[i],1) consecutive
// packets before the turn passes to the next port.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : per-port beat valid
//   in_data     : per-port beat data
//   in_last     : per-port last-beat-of-packet flag
//   in_ready    : per-port beat accepted (combinational)
//   weight      : per-port packets per turn (0 behaves as 1)
//   out_valid   : registered output valid
//   out_data    : registered output data
//   out_last    : registered output last flag
//   out_id      : source port of the current output beat
//   out_ready   : downstream accepts the output beat
`timescale 1ns/1ps

module arbiter_rr_weighted #(
    parameter int Port    = 4,
    parameter int Width   = 32,
    parameter int WeightW = 4,
    parameter int IdW     = (Port > 1) ? $clog2(Port) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [Port-1:0]                 in_valid,
    input  logic [Port-1:0][Width-1:0]      in_data,
    input  logic [Port-1:0]                 in_last,
    output logic [Port-1:0]                 in_ready,
    input  logic [Port-1:0][WeightW-1:0]    weight,
    output logic                            out_valid,
    output logic [Width-1:0]                out_data,
    output logic                            out_last,
    output logic [IdW-1:0]                  out_id,
    input  logic                            out_ready
);

    logic [IdW-1:0]     ptr;
    logic [WeightW-1:0] cnt;
    logic               locked;
    logic [IdW-1:0]     lock_id;

    logic               load_en;
    logic               sel_found;
    logic               xfer;
    logic [IdW-1:0]     sel;
    logic [IdW-1:0]     idx;
    logic [WeightW:0]   w_eff;
    logic [WeightW:0]   cnt_inc;
    logic               cnt_keep;
    logic [IdW-1:0]     ptr_next_turn;

    // Grant selection: locked port, or first valid port circularly from ptr
    always_comb begin
        load_en   = !out_valid || out_ready;
        sel       = lock_id;
        sel_found = 1'b0;
        idx       = '0;
        if (locked) begin
            sel_found = in_valid[lock_id];
        end else begin
            for (int k = 0; k < Port; k++) begin
                idx = IdW'((int'(ptr) + k) % Port);
                if (!sel_found && in_valid[idx]) begin
                    sel       = idx;
                    sel_found = 1'b1;
                end
            end
        end

        // A locked port is offered ready even while it is idle, so it can
        // resume its packet the moment it raises valid again.
        in_ready = '0;
        if (!rst && load_en && (locked || sel_found)) begin
            in_ready[sel] = 1'b1;
        end
        xfer = !rst && load_en && sel_found;
    end

    // Turn bookkeeping, only consulted when a packet completes
    always_comb begin
        w_eff    = (weight[sel] == '0) ? (WeightW+1)'(1) : {1'b0, weight[sel]};
        cnt_inc  = {1'b0, cnt} + (WeightW+1)'(1);
        cnt_keep = (sel == ptr) && (cnt_inc < w_eff);
        if (int'(sel) == Port - 1) begin
            ptr_next_turn = '0;
        end else begin
            ptr_next_turn = sel + IdW'(1);
        end
    end

    // Output register and arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            locked    <= 1'b0;
            lock_id   <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[sel];
                out_last  <= in_last[sel];
                out_id    <= sel;
                if (!in_last[sel]) begin
                    locked  <= 1'b1;
                    lock_id <= sel;
                end else begin
                    locked <= 1'b0;
                    if (cnt_keep) begin
                        cnt <= cnt_inc[WeightW-1:0];
                    end else begin
                        ptr <= ptr_next_turn;
                        cnt <= '0;
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_rr_weighted.sv
// Testbench for arbiter_rr_weighted (Port=4, Width=32, WeightW=4).
// Directed steps followed by a randomized phase, all compared against a
// behavioural model of the arbitration rules kept in integer variables.
`timescale 1ns/1ps

module tb_arbiter_rr_weighted;

    localparam int P  = 4;
    localparam int W  = 32;
    localparam int WW = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [P-1:0]        in_valid;
    logic [P-1:0][W-1:0] in_data;
    logic [P-1:0]        in_last;
    logic [P-1:0]        in_ready;
    logic [P-1:0][WW-1:0] weight;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic                out_last;
    logic [IW-1:0]       out_id;
    logic                out_ready;

    arbiter_rr_weighted #(.Port(P), .Width(W), .WeightW(WW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .weight(weight),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // model state
    int          mptr, mcnt, mlock;
    bit          mlocked;
    bit          mv, ml;
    logic [W-1:0] md;
    int          mid;
    int          g_pred;
    bit          xfer_pred;
    int          send_seq [P];
    int          exp_seq  [P];
    bit          sb_on = 1'b0;

    int pat [7] = '{0, 0, 0, 1, 2, 3, 3};
    logic [3:0] lk_valid [6] = '{4'b0010, 4'b1111, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
    logic [3:0] lk_last  [6] = '{4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mptr = 0; mcnt = 0; mlock = 0; mlocked = 0;
        mv = 0; ml = 0; md = '0; mid = 0;
        for (int p = 0; p < P; p++) begin
            send_seq[p] = 0;
            exp_seq[p]  = 0;
        end
    endtask

    task automatic drive_data();
        for (int p = 0; p < P; p++) in_data[p] = {8'(p), 24'(send_seq[p])};
    endtask

    // Which port the rules grant now, and the in_ready vector they imply.
    task automatic predict(output logic [P-1:0] rdy);
        bit le;
        le = !mv || out_ready;
        g_pred = -1;
        rdy = '0;
        if (mlocked) begin
            if (in_valid[mlock]) g_pred = mlock;
            if (le) rdy[mlock] = 1'b1;
        end else begin
            for (int k = 0; k < P; k++) begin
                if (g_pred < 0 && in_valid[(mptr + k) % P]) g_pred = (mptr + k) % P;
            end
            if (g_pred >= 0 && le) rdy[g_pred] = 1'b1;
        end
        xfer_pred = (g_pred >= 0) && le;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        logic [P-1:0] rdy_exp;
        bit           stall;
        logic [W-1:0] pd;
        bit           pl;
        logic [IW-1:0] pid;
        int           weff;
        #1;
        predict(rdy_exp);
        chk("in_ready", in_ready, rdy_exp);
        stall = out_valid && !out_ready;
        pd = out_data; pl = out_last; pid = out_id;
        @(posedge clk);
        #1;
        if (xfer_pred) begin
            mv = 1; md = in_data[g_pred]; ml = in_last[g_pred]; mid = g_pred;
            if (!in_last[g_pred]) begin
                mlocked = 1; mlock = g_pred;
            end else begin
                mlocked = 0;
                weff = (weight[g_pred] == 0) ? 1 : int'(weight[g_pred]);
                if (g_pred == mptr && mcnt + 1 < weff) mcnt++;
                else begin
                    mptr = (g_pred + 1) % P;
                    mcnt = 0;
                end
            end
            send_seq[g_pred]++;
        end else if (out_ready) begin
            mv = 0;
        end
        chk("out_valid", out_valid, mv);
        if (mv) begin
            chk("out_data", out_data, md);
            chk("out_last", out_last, ml);
            chk("out_id", out_id, mid);
        end
        if (stall) begin
            chk("stall_data", out_data, pd);
            chk("stall_last", out_last, pl);
            chk("stall_id", out_id, pid);
        end
        if (sb_on && xfer_pred) begin
            chk("sb_order", out_data[23:0], 24'(exp_seq[out_id]));
            exp_seq[out_id]++;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset with every port requesting
        rst = 1'b1;
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        for (int p = 0; p < P; p++) weight[p] = 4'd1;
        model_reset();
        drive_data();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 chk("first_grant", in_ready, 4'b0001);
        cycle();
        chk("first_id", out_id, 0);

        // Fair single-beat rotation
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            drive_data();
            cycle();
            chk("fair_id", out_id, i % 4);
        end

        // Weighted turns {3,1,0,2}
        reset_dut();
        weight[0] = 4'd3; weight[1] = 4'd1; weight[2] = 4'd0; weight[3] = 4'd2;
        for (int i = 0; i < 14; i++) begin
            drive_data();
            cycle();
            chk("wrr_id", out_id, pat[i % 7]);
        end

        // Packet lock with a 2-cycle gap on the locked port
        reset_dut();
        for (int p = 0; p < P; p++) weight[p] = 4'd1;
        for (int s = 0; s < 6; s++) begin
            in_valid = lk_valid[s];
            in_last  = lk_last[s];
            drive_data();
            #1 chk("lock_ready", in_ready, 4'b0010);
            cycle();
            if (out_valid) chk("lock_id", out_id, 1);
        end
        in_valid = 4'hF; in_last = 4'hF;
        drive_data();
        cycle();
        chk("after_lock_id", out_id, 2);

        // Reset during beat 2 of a 3-beat packet on port 2
        reset_dut();
        in_valid = 4'b0100; in_last = 4'b1011;
        for (int s = 0; s < 2; s++) begin
            drive_data();
            cycle();
        end
        chk("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'hF; in_last = 4'hF;
        drive_data();
        #1 chk("post_rst_grant", in_ready, 4'b0001);
        cycle();
        chk("post_rst_id", out_id, 0);

        // Random packets with random backpressure
        reset_dut();
        sb_on = 1'b1;
        for (int p = 0; p < P; p++) weight[p] = WW'($urandom_range(0, 3));
        for (int i = 0; i < 600; i++) begin
            if (i % 97 == 0) begin
                for (int p = 0; p < P; p++) weight[p] = WW'($urandom_range(0, 3));
            end
            in_valid = P'($urandom);
            for (int p = 0; p < P; p++) in_last[p] = ($urandom_range(0, 2) == 0);
            out_ready = $urandom_range(0, 1) == 1;
            drive_data();
            cycle();
        end
        in_valid = '0;
        out_ready = 1'b1;
        repeat (3) begin
            drive_data();
            cycle();
        end
        for (int p = 0; p < P; p++) chk("sb_count", exp_seq[p], send_seq[p]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_weighted.md
# arbiter_rr_weighted

Parametrised weighted round-robin arbiter with packet locking and a registered output stage. It merges `Port` valid/ready input streams into one output stream. A multi-beat packet (terminated by `in_last`) is never interleaved with another port's data. Each port may send up to `weight[i]` consecutive packets per turn. It sits wherever several masters share one downstream channel (bus request merge, NoC injection) and replaces the single-beat round-robin arbiter where packets or unequal bandwidth shares are needed.

## Interface
Parameters:
- `Port`, 4, number of input ports (>=1)
- `Width`, 32, data width per beat
- `WeightW`, 4, width of each per-port weight
- `IdW`, derived: `Port>1 ? $clog2(Port) : 1`

Ports:
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: reset, asynchronous, active-high
- `in_valid` input `[Port-1:0]`: per-port beat valid
- `in_data` input `[Port-1:0][Width-1:0]`: per-port beat data
- `in_last` input `[Port-1:0]`: beat is the last of its packet
- `in_ready` output `[Port-1:0]`: per-port beat accepted (combinational)
- `weight` input `[Port-1:0][WeightW-1:0]`: packets per turn per port; 0 is treated as 1
- `out_valid` output 1: registered output valid
- `out_data` output `[Width-1:0]`: registered output data
- `out_last` output 1: registered last flag
- `out_id` output `[IdW-1:0]`: index of the source port of the current output beat
- `out_ready` input 1: downstream accepts the output beat

## Operation
- State: `ptr` (IdW bits, highest-priority port), `cnt` (WeightW bits, packets completed by `ptr` in this turn), `locked` (1 bit), `lock_id` (IdW bits), plus the output register.
- `load_en = !out_valid || out_ready`. The output register loads only when `load_en` is high.
- Unlocked: `sel` is the first port with `in_valid` high, searching circularly from `ptr` upward. `in_ready[sel] = load_en`; all other `in_ready` bits are 0. If no port is valid, all `in_ready` bits are 0 and the state is unchanged.
- Locked: `in_ready[lock_id] = load_en`; all other bits are 0. Other ports' `in_valid` is ignored. If `in_valid[lock_id]` drops, the arbiter waits on that port.
- Transfer on port g = `in_valid[g] && in_ready[g]`. The output register loads `{1, in_data[g], in_last[g], g}`.
- Transfer with `in_last=0`: set `locked=1`, `lock_id=g`.
- Transfer with `in_last=1` (packet complete): clear `locked`. Then update weights:
  - If g==`ptr` and `cnt+1 < max(weight[g],1)`: increment `cnt`, keep `ptr`.
  - Otherwise: `ptr=(g+1) mod Port`, `cnt=0`.
- Weights are sampled only at packet completion, so changing them mid-packet is legal.
- A single-beat packet (first beat has `in_last=1`) never sets `locked`.
- If `load_en=1` and no transfer occurs, the register clears `out_valid` only when `out_ready` was high. Otherwise it holds.
- Port=1: always selects port 0, `out_id=0`, behaves as a pipeline register with a packet flag.

## Timing
- Reset values (asynchronous on `rst` high): `out_valid=0`, `out_data=0`, `out_last=0`, `out_id=0`, `ptr=0`, `cnt=0`, `locked=0`. `in_ready` is 0 during reset.
- Latency: an input beat appears on `out_*` one cycle after its transfer.
- Throughput: one beat per cycle while `out_ready=1` and the selected port stays valid. There are no bubbles at packet or port boundaries.
- Backpressure: while `out_valid=1 && out_ready=0`, all `out_*` signals hold stable and all `in_ready` bits are 0.
- `in_ready` is combinational from `in_valid`, `out_ready` and state. Upstream must not make `in_valid` depend on `in_ready`.
- Simultaneous events:
  - Output drain and new load in the same cycle is a normal transfer.
  - A last beat of port g with another port valid in the same cycle: the next cycle's `sel` uses the updated `ptr`.
- Reset mid-packet: lock, credits and any output beat are discarded. Upstream is responsible for packet recovery.

## Test plan
- Reset and idle: assert `rst` with all `in_valid=1` -> all outputs 0, `in_ready=0`. Deassert `rst` -> port 0 is granted first.
- Fair single-beat: Port=4, all weights 1, all ports always valid with `in_last=1`, `out_ready=1` -> `out_id` sequence 0,1,2,3,0,… at one beat per cycle.
- Weights: weights {3,1,0,2}, all valid, single-beat packets -> `out_id` pattern 0,0,0,1,2,3,3 repeating.
- Packet lock: port 1 sends a 4-beat packet while ports 0, 2 and 3 are valid, and port 1 drops `in_valid` for 2 cycles mid-packet -> `out_id=1` for all 4 beats, no other port is granted, `in_ready` for the other ports stays 0.
- Backpressure: random `out_ready` (50%) with random packets -> `out_*` stable while stalled, and the scoreboard per port receives all beats in order with `out_last` matching.
- Mid-packet reset: assert `rst` during beat 2 of a 3-beat packet -> `out_valid=0` immediately, `locked` cleared, and the next grant after reset follows `ptr=0`.
